// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Column-strobe scanner for a small matrix keypad. Rows are synchronized,
// sampled at the end of each column window, debounced per key over several
// full scans, and every debounced change is reported as a key event.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   row_in       raw row sense lines (asynchronous, active high)
//   col_out      one-hot column drive, active high
//   key_valid    event available
//   key_ready    consumer accepts event
//   key_code     key index = row*COLS + col
//   key_pressed  1 = press, 0 = release
//   key_state    debounced key bitmap
//   dropped      sticky: an event was overwritten before it was reported
module keypad_scan_ctrl #(
   parameter int unsigned ROWS           = 2,
   parameter int unsigned COLS           = 2,
   parameter int unsigned SCAN_DIV       = 12000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic [ROWS-1:0]                                       row_in,
   output logic [COLS-1:0]                                       col_out,
   output logic                                                  key_valid,
   input  logic                                                  key_ready,
   output logic [((ROWS*COLS) > 1 ? $clog2(ROWS*COLS) : 1)-1:0]  key_code,
   output logic                                                  key_pressed,
   output logic [ROWS*COLS-1:0]                                  key_state,
   output logic                                                  dropped
);

   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned BW = 4;

   typedef enum logic [1:0] {IDLE, DRIVE, UPDATE} state_t;

   state_t          state;
   logic [CW-1:0]   col;
   logic [DW-1:0]   div;
   logic [ROWS-1:0] row_s1, row_s2;
   logic [N-1:0]    raw, raw_next;
   logic [N-1:0]    deb, deb_next;
   logic [N-1:0]    pending, pend_next, pend_clr, flip;
   logic [BW-1:0]   cnt      [N];
   logic [BW-1:0]   cnt_next [N];
   logic            load_en;
   logic [KW-1:0]   load_idx;
   logic            drop_c;

   assign key_state = deb;

   // Raw capture at the last cycle of each column window
   always_comb begin
      raw_next = raw;
      if (state == DRIVE && div == DW'(SCAN_DIV - 1)) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
               if (col == CW'(c)) raw_next[r*COLS + c] = row_s2[r];
            end
         end
      end
   end

   // Per-key debounce, evaluated once per scan in UPDATE
   always_comb begin
      flip     = '0;
      deb_next = deb;
      for (int unsigned i = 0; i < N; i++) cnt_next[i] = cnt[i];
      if (state == UPDATE) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (raw[i] == deb[i]) begin
               cnt_next[i] = '0;
            end else if (cnt[i] == BW'(DEBOUNCE_SCANS - 1)) begin
               deb_next[i] = ~deb[i];
               cnt_next[i] = '0;
               flip[i]     = 1'b1;
            end else begin
               cnt_next[i] = cnt[i] + BW'(1);
            end
         end
      end
   end

   // Event slot loading: lowest pending index wins; a same-cycle flip keeps
   // the pending bit set so the newer change is reported afterwards.
   always_comb begin
      load_en  = (|pending) && (!key_valid || key_ready);
      load_idx = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (pending[i]) load_idx = KW'(i);
      end
      pend_clr = '0;
      if (load_en) pend_clr[load_idx] = 1'b1;
      pend_next = (pending & ~pend_clr) | flip;
      drop_c    = |(pending & ~pend_clr & flip);
   end

   // Scan FSM, debounce state and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         col         <= '0;
         div         <= '0;
         col_out     <= '0;
         row_s1      <= '0;
         row_s2      <= '0;
         raw         <= '0;
         deb         <= '0;
         pending     <= '0;
         key_valid   <= 1'b0;
         key_code    <= '0;
         key_pressed <= 1'b0;
         dropped     <= 1'b0;
         for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
         row_s1  <= row_in;
         row_s2  <= row_s1;
         raw     <= raw_next;
         deb     <= deb_next;
         pending <= pend_next;
         for (int unsigned i = 0; i < N; i++) cnt[i] <= cnt_next[i];
         if (drop_c) dropped <= 1'b1;

         if (load_en) begin
            key_valid   <= 1'b1;
            key_code    <= load_idx;
            key_pressed <= deb[load_idx];
         end else if (key_ready) begin
            key_valid   <= 1'b0;
         end

         case (state)
            IDLE: begin
               state   <= DRIVE;
               col     <= '0;
               div     <= '0;
               col_out <= COLS'(1);
            end
            DRIVE: begin
               if (div == DW'(SCAN_DIV - 1)) begin
                  div <= '0;
                  if (col == CW'(COLS - 1)) begin
                     state   <= UPDATE;
                     col_out <= '0;
                  end else begin
                     col     <= col + CW'(1);
                     col_out <= col_out << 1;
                  end
               end else begin
                  div <= div + DW'(1);
               end
            end
            UPDATE: begin
               state   <= DRIVE;
               col     <= '0;
               div     <= '0;
               col_out <= COLS'(1);
            end
            default: begin
               state   <= IDLE;
               col_out <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: a keypad model drives rows from the column
// strobes; expected events go into a queue and a monitor checks each transfer.
module tb_keypad_scan_ctrl;

   localparam int unsigned ROWS = 2;
   localparam int unsigned COLS = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] row_in;
   logic [1:0] col_out;
   logic       key_valid;
   logic       key_ready;
   logic [1:0] key_code;
   logic       key_pressed;
   logic [3:0] key_state;
   logic       dropped;

   logic [3:0] keys;
   logic [1:0] row_force;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [1:0] code;
      logic       pressed;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;

   keypad_scan_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEBOUNCE_SCANS(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
      .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
      .key_pressed(key_pressed), .key_state(key_state), .dropped(dropped)
   );

   always #5 clk = ~clk;

   // Keypad: key r*COLS+c connects column c to row r
   assign row_in[0] = row_force[0] | (keys[0] & col_out[0]) | (keys[1] & col_out[1]);
   assign row_in[1] = row_force[1] | (keys[2] & col_out[0]) | (keys[3] & col_out[1]);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [1:0] code, input logic pressed);
      ev_t e;
      e.code    = code;
      e.pressed = pressed;
      exp_q.push_back(e);
   endtask

   // Wait for the UPDATE cycle, then return just after it ends
   task automatic wait_update();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (col_out !== 2'b00 && n < 40);
      if (col_out !== 2'b00) begin
         vectors++;
         miscompares++;
         $display("FAIL scan_timeout: col_out %b never returned to 00", col_out);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_scans(input int n);
      repeat (n) wait_update();
   endtask

   // Monitor: every transfer is compared against the queue head
   always @(negedge clk) begin
      if (rst_n === 1'b1 && key_valid && key_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: code %0d pressed %0d, none expected",
                     key_code, key_pressed);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_code", 32'(key_code), 32'(mon_e.code));
            check("event_pressed", 32'(key_pressed), 32'(mon_e.pressed));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] pat [9];
      int n;
      pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};

      // Reset with rows forced high
      rst_n     = 1'b0;
      keys      = 4'b0000;
      row_force = 2'b11;
      key_ready = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rst_col_out", 32'(col_out), 32'd0);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_key_pressed", 32'(key_pressed), 32'd0);
      check("rst_key_state", 32'(key_state), 32'd0);
      check("rst_dropped", 32'(dropped), 32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      row_force = 2'b00;

      // Column sequence after release
      n = 0;
      @(negedge clk);
      while (col_out !== 2'b01 && n < 2) begin
         @(negedge clk);
         n++;
      end
      check("col_out_start", 32'(col_out), 32'h1);
      for (int k = 0; k < 18; k++) begin
         if (k != 0) @(negedge clk);
         check("col_seq", 32'(col_out), 32'(pat[k % 9]));
      end

      // Single press of key 1, then release
      key_ready = 1'b1;
      wait_update();
      keys = 4'b0010;
      push(2'd1, 1'b1);
      wait_scans(3);
      @(negedge clk);
      check("press_latency_early", 32'(key_valid), 32'd0);
      @(negedge clk);
      check("press_latency_valid", 32'(key_valid), 32'd1);
      wait_update();
      check("press_key_state", 32'(key_state), 32'h2);
      keys = 4'b0000;
      push(2'd1, 1'b0);
      wait_scans(4);
      check("release_key_state", 32'(key_state), 32'h0);

      // Bounce on key 2: never three consecutive scans
      keys = 4'b0100; wait_scans(2);
      keys = 4'b0000; wait_scans(1);
      keys = 4'b0100; wait_scans(2);
      keys = 4'b0000; wait_scans(4);
      check("bounce_key_state", 32'(key_state), 32'h0);

      // Backpressure: keys 0 and 3 together
      key_ready = 1'b0;
      keys = 4'b1001;
      wait_scans(4);
      check("bp_valid", 32'(key_valid), 32'd1);
      check("bp_code", 32'(key_code), 32'd0);
      check("bp_pressed", 32'(key_pressed), 32'd1);
      check("bp_key_state", 32'(key_state), 32'h9);
      repeat (5) @(negedge clk);
      check("bp_hold_valid", 32'(key_valid), 32'd1);
      check("bp_hold_code", 32'(key_code), 32'd0);
      push(2'd0, 1'b1);
      push(2'd3, 1'b1);
      @(posedge clk);
      #1;
      key_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      key_ready = 1'b0;
      @(negedge clk);
      check("bp_drained_valid", 32'(key_valid), 32'd0);
      check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
      key_ready = 1'b1;
      wait_update();
      keys = 4'b0000;
      push(2'd0, 1'b0);
      push(2'd3, 1'b0);
      wait_scans(4);

      // Overflow: press, release, press while stalled
      key_ready = 1'b0;
      keys = 4'b0001; wait_scans(4);
      check("ovf_first_valid", 32'(key_valid), 32'd1);
      check("ovf_first_dropped", 32'(dropped), 32'd0);
      keys = 4'b0000; wait_scans(4);
      check("ovf_second_dropped", 32'(dropped), 32'd0);
      keys = 4'b0001; wait_scans(4);
      check("ovf_dropped", 32'(dropped), 32'd1);
      check("ovf_hold_code", 32'(key_code), 32'd0);
      check("ovf_hold_pressed", 32'(key_pressed), 32'd1);
      push(2'd0, 1'b1);
      push(2'd0, 1'b1);
      key_ready = 1'b1;
      repeat (4) @(posedge clk);
      wait_update();
      keys = 4'b0000;
      push(2'd0, 1'b0);
      wait_scans(4);
      check("ovf_sticky", 32'(dropped), 32'd1);
      check("ovf_key_state", 32'(key_state), 32'h0);

      // Reset while an event is waiting
      key_ready = 1'b0;
      keys = 4'b0010;
      wait_scans(4);
      @(negedge clk);
      check("mid_valid_before", 32'(key_valid), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", 32'(key_valid), 32'd0);
      check("mid_rst_key_state", 32'(key_state), 32'h0);
      check("mid_rst_dropped", 32'(dropped), 32'd0);
      check("mid_rst_col_out", 32'(col_out), 32'd0);
      keys = 4'b0000;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      key_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
